// File: rtl/sr_latch_ctrl.sv
// Pulse controller for an external NOR SR latch: arbitrates set/reset requests,
// drives a fixed-width S or R pulse, lets the latch settle, and verifies it by readback.
module sr_latch_ctrl #(
  parameter int PULSE_W  = 2,
  parameter int SETTLE_W = 3,
  parameter int GAP_W    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_req,
  output logic       set_ack,
  input  logic       rst_req,
  output logic       rst_ack,
  output logic       S,
  output logic       R,
  input  logic       Q,
  input  logic       Qn,
  output logic       busy,
  output logic       err,
  input  logic       err_clr,
  output logic       state_q,
  output logic [2:0] dbg_state
);

  // Requests are level handshakes: a requester holds req high until it sees its
  // one-cycle ack, and drops req in the following cycle.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    GAP    = 3'd4,
    ERR    = 3'd5
  } fsm_t;

  localparam logic [3:0] PULSE_LD  = 4'(PULSE_W - 1);
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_W - 1);
  localparam logic [3:0] GAP_LD    = 4'(GAP_W - 1);

  fsm_t       state, state_d;
  logic [3:0] cnt, cnt_d;
  logic       cmd, cmd_d;
  logic       rr_set, rr_set_d;
  logic       q_s1, q_s2, qn_s1, qn_s2;
  logic       pass;
  logic       s_d, r_d, set_ack_d, rst_ack_d, err_d, state_q_d;

  // Q/Qn are asynchronous to clk; only the second flop stage is ever used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_s1  <= 1'b0;
      q_s2  <= 1'b0;
      qn_s1 <= 1'b1;
      qn_s2 <= 1'b1;
    end else begin
      q_s1  <= Q;
      q_s2  <= q_s1;
      qn_s1 <= Qn;
      qn_s2 <= qn_s1;
    end
  end

  assign pass = (q_s2 != qn_s2) && (q_s2 == cmd);

  // State register plus registered outputs, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      cmd     <= 1'b0;
      rr_set  <= 1'b0;
      S       <= 1'b0;
      R       <= 1'b0;
      set_ack <= 1'b0;
      rst_ack <= 1'b0;
      err     <= 1'b0;
      state_q <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      cmd     <= cmd_d;
      rr_set  <= rr_set_d;
      S       <= s_d;
      R       <= r_d;
      set_ack <= set_ack_d;
      rst_ack <= rst_ack_d;
      err     <= err_d;
      state_q <= state_q_d;
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    cmd_d    = cmd;
    rr_set_d = rr_set;
    case (state)
      IDLE: begin
        if (set_req || rst_req) begin
          state_d = DRIVE;
          cnt_d   = PULSE_LD;
          cmd_d   = (set_req && rst_req) ? rr_set : set_req;
        end
      end
      DRIVE: begin
        if (cnt == 4'd0) begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LD;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      SETTLE: begin
        if (cnt == 4'd0) state_d = CHECK;
        else             cnt_d   = cnt - 4'd1;
      end
      CHECK: begin
        if (pass) begin
          state_d  = GAP;
          cnt_d    = GAP_LD;
          rr_set_d = ~cmd;  // favour whoever was not just served
        end else begin
          state_d = ERR;
        end
      end
      GAP: begin
        if (cnt == 4'd0) state_d = IDLE;
        else             cnt_d   = cnt - 4'd1;
      end
      ERR: begin
        if (err_clr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Drives are computed from the next state so S/R rise on the granting edge.
  always_comb begin
    s_d       = (state_d == DRIVE) && cmd_d;
    r_d       = (state_d == DRIVE) && !cmd_d;
    set_ack_d = (state == CHECK) && pass && cmd;
    rst_ack_d = (state == CHECK) && pass && !cmd;
    state_q_d = ((state == CHECK) && pass) ? cmd : state_q;
    err_d     = err;
    if ((state == CHECK) && !pass)      err_d = 1'b1;
    else if ((state == ERR) && err_clr) err_d = 1'b0;
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Bench for sr_latch_ctrl: default-parameter instance checked through an event
// scoreboard, plus a PULSE_W=1/GAP_W=2 instance for back-to-back timing.
module tb_sr_latch_ctrl;

  localparam int W = 20;  // {set_ack, rst_ack, err, state_q, cycle[15:0]}

  logic clk = 1'b0;
  logic rst_n;
  logic set_req, rst_req, err_clr;
  logic set_ack, rst_ack, S, R, Q, Qn, busy, err, state_q;
  logic [2:0] dbg_state;
  logic bad, lq;

  logic b_set_req, b_rst_req;
  logic b_set_ack, b_rst_ack, b_S, b_R, b_Q, b_Qn, b_busy, b_err, b_state_q;
  logic [2:0] b_dbg_state;
  logic b_lq;

  logic [W-1:0] exp_q[$];
  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int overlap = 0;
  bit sq = 1'b0;
  logic err_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  sr_latch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .set_req(set_req), .set_ack(set_ack),
    .rst_req(rst_req), .rst_ack(rst_ack), .S(S), .R(R), .Q(Q), .Qn(Qn),
    .busy(busy), .err(err), .err_clr(err_clr), .state_q(state_q),
    .dbg_state(dbg_state)
  );

  sr_latch_ctrl #(.PULSE_W(1), .SETTLE_W(3), .GAP_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .set_req(b_set_req), .set_ack(b_set_ack),
    .rst_req(b_rst_req), .rst_ack(b_rst_ack), .S(b_S), .R(b_R), .Q(b_Q), .Qn(b_Qn),
    .busy(b_busy), .err(b_err), .err_clr(1'b0), .state_q(b_state_q),
    .dbg_state(b_dbg_state)
  );

  // NOR latch models; 'bad' forces the invalid Q=Qn=0 condition.
  always @(S or R) begin
    #1;
    if (S) lq = 1'b1;
    else if (R) lq = 1'b0;
  end
  assign Q  = bad ? 1'b0 : lq;
  assign Qn = bad ? 1'b0 : ~lq;

  always @(b_S or b_R) begin
    #1;
    if (b_S) b_lq = 1'b1;
    else if (b_R) b_lq = 1'b0;
  end
  assign b_Q  = b_lq;
  assign b_Qn = ~b_lq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  // Monitor: every ack pulse or err rising edge pops one expected event.
  always @(negedge clk) begin
    logic [W-1:0] act, e;
    if (rst_n && (set_ack || rst_ack || (err && !err_prev))) begin
      act = {set_ack, rst_ack, err, state_q, 16'(cyc)};
      if (exp_q.size() == 0) begin
        chk("unexpected_event", 32'(act), 32'hFFFFFFFF);
      end else begin
        e = exp_q.pop_front();
        chk("event", 32'(act), 32'(e));
      end
    end
    err_prev = err;
    if (S && R) overlap++;
  end

  task automatic wait_sig(input int which, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 25 && !seen; i++) begin
      @(negedge clk);
      case (which)
        0: seen = set_ack;
        1: seen = rst_ack;
        2: seen = err;
        3: seen = b_set_ack;
        4: seen = b_rst_ack;
        default: seen = b_R;
      endcase
    end
  endtask

  task automatic do_cmd(input bit is_set, input bit fail);
    int k;
    bit seen;
    @(negedge clk);
    if (is_set) set_req = 1'b1; else rst_req = 1'b1;
    k = cyc + 1;
    exp_q.push_back({is_set & !fail, !is_set & !fail, fail, fail ? sq : is_set, 16'(k + 6)});
    if (!fail) sq = is_set;
    repeat (2) begin
      @(negedge clk);
      chk("drive_hi", {30'd0, S, R}, is_set ? 32'd2 : 32'd1);
    end
    @(negedge clk);
    chk("drive_lo", {30'd0, S, R}, 32'd0);
    wait_sig(fail ? 2 : (is_set ? 0 : 1), seen);
    chk("done_seen", 32'(seen), 32'd1);
    set_req = 1'b0;
    rst_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, rc;
    bit seen;
    rst_n = 1'b0; set_req = 1'b0; rst_req = 1'b0; err_clr = 1'b0; bad = 1'b0; lq = 1'b0;
    b_set_req = 1'b0; b_rst_req = 1'b0; b_lq = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {25'd0, S, R, set_ack, rst_ack, busy, err, state_q}, 32'd0);
    chk("reset_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;

    // Simultaneous requests right after reset: reset command wins first.
    @(negedge clk);
    set_req = 1'b1; rst_req = 1'b1;
    k = cyc + 1;
    exp_q.push_back({1'b0, 1'b1, 1'b0, 1'b0, 16'(k + 6)});
    exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b1, 16'(k + 14)});
    sq = 1'b1;
    @(negedge clk);
    chk("arb_r_first", {30'd0, S, R}, 32'd1);
    wait_sig(1, seen);
    chk("arb_rst_ack", 32'(seen), 32'd1);
    rst_req = 1'b0;
    wait_sig(0, seen);
    chk("arb_set_ack", 32'(seen), 32'd1);
    set_req = 1'b0;

    // Redundant set while state_q=1.
    do_cmd(1'b1, 1'b0);
    chk("redundant_err", 32'(err), 32'd0);

    // Reset then a plain set; busy must be low two cycles after ack.
    do_cmd(1'b0, 1'b0);
    do_cmd(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    chk("busy_low", 32'(busy), 32'd0);

    // Invalid latch during a set: err, no ack, then err_clr.
    bad = 1'b1;
    do_cmd(1'b1, 1'b1);
    chk("err_drives", {29'd0, S, R, set_ack}, 32'd0);
    chk("err_state", 32'(dbg_state), 32'd5);
    repeat (2) @(negedge clk);
    chk("err_sticky", {30'd0, err, busy}, 32'd3);
    bad = 1'b0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_cleared", {29'd0, err, busy, state_q}, {31'd0, sq});

    // Async reset during DRIVE aborts; held request reruns after release.
    @(negedge clk);
    set_req = 1'b1;
    @(negedge clk);
    chk("abort_drive", 32'(S), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("abort_async", {28'd0, S, R, set_ack, busy}, 32'd0);
    chk("abort_state_q", 32'(state_q), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    k = cyc + 1;
    exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b1, 16'(k + 6)});
    sq = 1'b1;
    wait_sig(0, seen);
    chk("rerun_ack", 32'(seen), 32'd1);
    set_req = 1'b0;

    // PULSE_W=1, GAP_W=2: set then reset back to back.
    @(negedge clk);
    b_set_req = 1'b1;
    k = cyc + 1;
    wait_sig(3, seen);
    chk("b_set_ack_cyc", 32'(cyc), 32'(k + 5));
    b_set_req = 1'b0;
    b_rst_req = 1'b1;
    wait_sig(5, seen);
    rc = cyc;
    chk("b_gap_hold", 32'(seen && rc >= k + 7 && rc <= k + 8), 32'd1);
    wait_sig(4, seen);
    chk("b_rst_ack_cyc", 32'(cyc), 32'(rc + 5));
    b_rst_req = 1'b0;
    @(negedge clk);
    chk("b_state_q", {30'd0, b_state_q, b_err}, 32'd0);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("no_overlap", 32'(overlap), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sr_latch_ctrl.md
SR_LATCH_CTRL -- requirements
Module: sr_latch_ctrl

Interface
REQ-001 Parameter PULSE_W, default 2: number of clock cycles S or R is held high per command; legal range 1..15.
REQ-002 Parameter SETTLE_W, default 3: number of idle-drive cycles between pulse end and readback check; legal range 3..15.
REQ-003 Parameter GAP_W, default 1: number of cycles after ack during which requests are ignored; legal range 1..15.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 set_req  in  1  set requester command, held high until set_ack.
REQ-007 set_ack  out  1  one-cycle completion pulse to the set requester.
REQ-008 rst_req  in  1  reset requester command, held high until rst_ack.
REQ-009 rst_ack  out  1  one-cycle completion pulse to the reset requester.
REQ-010 S  out  1  registered set drive to the external NOR SR latch.
REQ-011 R  out  1  registered reset drive to the external NOR SR latch.
REQ-012 Q  in  1  latch output, asynchronous to clk.
REQ-013 Qn  in  1  latch complementary output, asynchronous to clk.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 err  out  1  sticky readback-failure flag.
REQ-016 err_clr  in  1  clears err and returns the FSM to IDLE.
REQ-017 state_q  out  1  last latch value confirmed by a successful check.

Function
REQ-018 Q and Qn SHALL each pass through a 2-flop synchronizer; CHECK SHALL use only the synchronized values.
REQ-019 FSM states SHALL be IDLE, DRIVE, SETTLE, CHECK, GAP and ERR.
REQ-020 IDLE: set_req and rst_req are sampled, and a granted request moves the FSM to DRIVE at that edge.
REQ-021 Arbitration: a sole requester wins; on a simultaneous request the round-robin pointer decides. The pointer resets to favour rst_req and toggles to the other requester after each successful command.
REQ-022 DRIVE: for exactly PULSE_W cycles, S=1 (set command) or R=1 (reset command); the other drive stays 0.
REQ-023 S and R SHALL never both be 1 in any cycle, including during reset.
REQ-024 SETTLE: S=R=0 for exactly SETTLE_W cycles, then the FSM moves to CHECK.
REQ-025 CHECK is one cycle, with synchronized values Qs and Qns.
- Pass when Qs!=Qns and Qs equals the commanded value (1 for set, 0 for reset).
- On pass: update state_q, pulse the matching ack for one cycle, and enter GAP.
REQ-026 CHECK failure: enter ERR, set err=1, and issue no ack; the pending requester stays unacknowledged.
- Failure is Qs==Qns (invalid or metastable latch) or the wrong polarity.
REQ-027 Latency: with the request sampled at edge k, the drive rises at k, falls at k+PULSE_W, and ack is high from edge k+PULSE_W+SETTLE_W+1 for one cycle. With default parameters, ack rises at k+6.
REQ-028 GAP lasts GAP_W cycles and ignores both requests; the requester SHALL deassert req in the cycle after it sees ack. GAP then returns to IDLE.
REQ-029 ERR holds S=R=0, ignores requests, and holds err=1 until err_clr=1 is sampled. It then clears err and goes to IDLE without changing state_q.
REQ-030 err_clr in any non-ERR state SHALL have no effect.
REQ-031 A redundant command (set while state_q=1, or reset while state_q=0) SHALL still execute the full pulse/check sequence.
REQ-032 Counters SHALL be 4 bits wide, load to the parameter value minus 1, and never wrap; a phase ends when its counter reaches 0.

Reset
REQ-033 rst_n=0 SHALL immediately force the following, with no clock required:
- S=0, R=0, set_ack=0, rst_ack=0, busy=0, err=0, state_q=0;
- FSM=IDLE, counters=0, round-robin pointer favouring rst_req;
- synchronizers cleared to Q=0, Qn=1.
REQ-034 Reset asserted mid-command SHALL abort the command with no ack; after reset release, a still-held request is re-arbitrated from IDLE.

Verification
REQ-035 Set, defaults, latch model responds: set_req at edge k -> S=1 for cycles k..k+1, set_ack high at k+6, state_q=1, busy low by k+8.
REQ-036 Simultaneous set_req and rst_req right after reset -> reset command runs first (R pulse, rst_ack); then set command runs (S pulse, set_ack); S and R never overlap.
REQ-037 Latch model forced to Q=Qn=0 during a set -> err=1 after CHECK, no set_ack, S=R=0; err_clr=1 -> err=0 and FSM back in IDLE with state_q unchanged.
REQ-038 rst_n pulled low during the DRIVE phase of a set -> S drops to 0 asynchronously, no ack; rst_n released with set_req still high -> full set sequence completes.
REQ-039 Back-to-back set then reset with PULSE_W=1, SETTLE_W=3, GAP_W=2 -> set_ack at k+5; requests ignored for 2 GAP cycles; reset command starts no earlier than k+7.
REQ-040 Redundant set while state_q=1 -> full S pulse issued, set_ack at k+6, state_q remains 1, err=0.
